// File: rtl/pipo_pkg.sv
// ----------------------------------------------------------------------------
// pipo_pkg
//   Types shared by the pipo register family. The serializer uses the two-state
//   FSM encoding below.
// ----------------------------------------------------------------------------
package pipo_pkg;

    // IDLE : no word held, serial output invalid
    // SHIFT: a word is being emitted, one bit per accepted serial beat
    typedef enum logic {
        IDLE,
        SHIFT
    } piso_state_t;

endpackage

// File: rtl/piso_serializer_mod_counter.sv
// ----------------------------------------------------------------------------
// piso_serializer_mod_counter
//   Modulo-MODULUS up-counter with synchronous clear and enable.
//   o_tc flags the terminal count (MODULUS-1); an enabled increment from the
//   terminal count wraps to zero. Clear takes priority over enable.
//
// Ports
//   i_clk  clock, all state on posedge
//   i_rst  synchronous active-high reset, count -> 0
//   i_clr  synchronous clear, count -> 0 (wins over i_en)
//   i_en   advance the count by one
//   o_tc   count == MODULUS-1
// ----------------------------------------------------------------------------
module piso_serializer_mod_counter #(
    parameter int unsigned MODULUS = 4,
    parameter int unsigned CW      = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CW-1:0] LastCount = CW'(MODULUS - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_tc;

    assign w_tc = (r_count == LastCount);
    assign o_tc = w_tc;

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_en) begin
            // Wrap explicitly so non-power-of-two moduli never pass LastCount.
            w_count_next = w_tc ? '0 : r_count + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in serial-out stage. Accepts a WIDTH-bit word over a valid/ready
//   handshake and emits it one bit per accepted serial beat, marking the final
//   bit with o_so_last. A new word can be accepted in the same cycle as the
//   last beat of the current one, so back-to-back words stream with no gap.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   i_clk        clock, all state on posedge
//   i_rst        synchronous active-high reset
//   i_pi         parallel word, sampled only on accept
//   i_pi_valid   i_pi holds a word to load
//   o_pi_ready   block can accept i_pi this cycle (combinational)
//   o_so         serial data bit (from register state)
//   o_so_valid   o_so is a valid bit
//   o_so_last    o_so is the final bit of the current word
//   i_so_ready   downstream consumes o_so this cycle
// ----------------------------------------------------------------------------
module piso_serializer
    import pipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pi,
    input  logic             i_pi_valid,
    output logic             o_pi_ready,
    output logic             o_so,
    output logic             o_so_valid,
    output logic             o_so_last,
    input  logic             i_so_ready
);

    piso_state_t      r_state;
    piso_state_t      w_state_next;
    logic [WIDTH-1:0] r_shift;

    logic w_so_valid;
    logic w_so_last;
    logic w_pi_ready;
    logic w_accept;
    logic w_beat;
    logic w_tc;

    assign w_accept = i_pi_valid && w_pi_ready;
    assign w_beat   = w_so_valid && i_so_ready;

    // ------------------------------------------------------------------------
    // Bit counter: cleared on every load, advanced on every beat. The final
    // beat wraps it back to zero, so IDLE always sees count 0.
    // ------------------------------------------------------------------------
    piso_serializer_mod_counter #(
        .MODULUS (WIDTH)
    ) u_bit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_accept),
        .i_en  (w_beat),
        .o_tc  (w_tc)
    );

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Last beat either chains straight into the next word or idles.
                if (w_beat && w_tc) begin
                    w_state_next = w_accept ? SHIFT : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // so_valid/so_last/so are pure functions of registered state, so they
    // change only on the clock edge. pi_ready looks at so_ready so the last
    // beat and the next load can share a cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_so_valid = (r_state == SHIFT);
        w_so_last  = (r_state == SHIFT) && w_tc;
        w_pi_ready = !i_rst &&
                     ((r_state == IDLE) || (w_so_valid && w_so_last && i_so_ready));
    end

    assign o_so_valid = w_so_valid;
    assign o_so_last  = w_so_last;
    assign o_pi_ready = w_pi_ready;
    assign o_so       = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

    // ------------------------------------------------------------------------
    // Shift register: load wins over shift so a chained word replaces the
    // finished one in the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= i_pi;
        end else if (w_beat) begin
            if (MSB_FIRST) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end else begin
                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            end
        end
    end

endmodule
